// File: rtl/adder_meas_pkg.sv
// ---------------------------------------------------------------------------
// adder_meas_pkg
// Shared definitions for the adder measurement sequencer:
//   - sequencer state encoding
//   - default operand / counter widths
//   - Galois LFSR tap mask and seed used by the optional self-sweep
//     (enabled by the ADDER_MEAS_LFSR_EN macro)
//   - result record layout {sum, cycles, err, timeout}
// No ports (package).
// ---------------------------------------------------------------------------
package adder_meas_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    // x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        CAPTURE,
        REPORT
    } state_t;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] sum;
        logic [DEF_CNT_W-1:0] cycles;
        logic                 err;
        logic                 timeout;
    } meas_res_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/adder_meas_sequencer_if.sv
// ---------------------------------------------------------------------------
// adder_meas_sequencer_if
// Command / result handshake between the LA-facing controller (master) and
// the measurement sequencer (slave).
//   cmd_valid  master->slave  command offered
//   cmd_ready  slave->master  command accepted when valid&ready
//   cmd_a/b    master->slave  operands
//   res_valid  slave->master  result record valid
//   res_ready  master->slave  result consumed
//   res_sum, res_cycles, res_err, res_timeout   slave->master result record
// ---------------------------------------------------------------------------
interface adder_meas_sequencer_if
    import adder_meas_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic [CNT_W-1:0] res_cycles;
    logic             res_err;
    logic             res_timeout;

    modport master (
        output cmd_valid, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_sum, res_cycles, res_err, res_timeout
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_sum, res_cycles, res_err, res_timeout
    );

endinterface

// File: rtl/adder_meas_sync.sv
// ---------------------------------------------------------------------------
// adder_meas_sync
// Two-flop synchroniser for the asynchronous adder completion flag, followed
// by an edge register that produces a one-cycle rising-edge pulse.
// Ports:
//   wb_clk_i   in  clock
//   wb_rst_n   in  synchronous reset, active low
//   async_in   in  asynchronous flag
//   sync_out   out synchronised level
//   rise_out   out one-cycle pulse on a synchronised 0->1 transition
// ---------------------------------------------------------------------------
module adder_meas_sync (
    input  logic wb_clk_i,
    input  logic wb_rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out
);

    logic chain_p0;
    logic chain_p1;
    logic chain_p2;

    // p0/p1: metastability filter; p2: previous synchronised level
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            chain_p0 <= 1'b0;
            chain_p1 <= 1'b0;
            chain_p2 <= 1'b0;
        end else begin
            chain_p0 <= async_in;
            chain_p1 <= chain_p0;
            chain_p2 <= chain_p1;
        end
    end

    assign sync_out = chain_p1;
    assign rise_out = chain_p1 & ~chain_p2;

endmodule

// File: rtl/adder_meas_sequencer.sv
// ---------------------------------------------------------------------------
// adder_meas_sequencer
// Controller-side driver for the instrumented Kogge-Stone adder. Accepts an
// operand command, loads the adder operands, enables the adder ring, times
// the synchronised completion flag and returns one checked result record per
// command.
// Optional feature macro: ADDER_MEAS_LFSR_EN adds sweep_en; while it is high
// in IDLE the block issues its own commands from a 32-bit Galois LFSR.
// Ports:
//   wb_clk_i     in   clock
//   wb_rst_n     in   synchronous reset, active low
//   active       in   design selected; low clears the FSM to IDLE
//   sweep_en     in   (ADDER_MEAS_LFSR_EN only) self-issue LFSR commands
//   bus          slave modport: cmd_* in, res_* out
//   adder_a/b    out  registered operands to the adder
//   adder_run    out  ring enable
//   adder_chain  in   asynchronous completion flag
//   adder_sum    in   adder result, sampled in CAPTURE
// ---------------------------------------------------------------------------
module adder_meas_sequencer
    import adder_meas_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int TIMEOUT = 'hFFF0,
    parameter int SETTLE  = 2
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_n,
    input  logic                   active,
`ifdef ADDER_MEAS_LFSR_EN
    input  logic                   sweep_en,
`endif
    adder_meas_sequencer_if.slave  bus,
    output logic [WIDTH-1:0]       adder_a,
    output logic [WIDTH-1:0]       adder_b,
    output logic                   adder_run,
    input  logic                   adder_chain,
    input  logic [WIDTH-1:0]       adder_sum
);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] settle_q;
    logic             chain_sync;
    logic             chain_rise;
    logic             start;
    logic             timed_out;

    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cycles_q;
    logic             err_q;
    logic             timeout_q;

    // Sum check is modulo 2**WIDTH: the adder's carry-out is not part of it.
    function automatic logic sum_mismatch(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0] want;
        want = a + b;
        return s != want;
    endfunction

    adder_meas_sync u_sync (
        .wb_clk_i (wb_clk_i),
        .wb_rst_n (wb_rst_n),
        .async_in (adder_chain),
        .sync_out (chain_sync),
        .rise_out (chain_rise)
    );

`ifdef ADDER_MEAS_LFSR_EN
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_a;
    logic [31:0] lfsr_b;
    logic        self_issue;

    // Two steps per command: A takes the first, B the second.
    assign lfsr_a     = lfsr_step(lfsr_q);
    assign lfsr_b     = lfsr_step(lfsr_a);
    assign self_issue = sweep_en && active && (state_q == IDLE);
    assign start      = self_issue || (!sweep_en && bus.cmd_valid && bus.cmd_ready);

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (self_issue) begin
            lfsr_q <= lfsr_b;
        end
    end
`else
    assign start = bus.cmd_valid && bus.cmd_ready;
`endif

    assign timed_out = (cnt_q == CNT_W'(TIMEOUT));

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            // A flag still high from the previous run must clear first,
            // otherwise its level would hide the next rising edge.
            LOAD:    if (!chain_sync && (settle_q >= CNT_W'(SETTLE - 1))) state_d = RUN;
            RUN: begin
                if (chain_rise) begin
                    state_d = CAPTURE;
                end else if (timed_out) begin
                    state_d = REPORT;
                end
            end
            CAPTURE: state_d = REPORT;
            REPORT:  if (bus.res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (!active) begin
            state_d = IDLE;
        end
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        adder_run     = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
`ifdef ADDER_MEAS_LFSR_EN
            // The host is told "not ready" while the sweep owns the adder.
            IDLE:    bus.cmd_ready = active && !sweep_en;
`else
            IDLE:    bus.cmd_ready = active;
`endif
            RUN:     adder_run     = active;
            REPORT:  bus.res_valid = active;
            default: ;
        endcase
    end

    // Counter, operand and result-record registers
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            cnt_q     <= '0;
            settle_q  <= '0;
            adder_a   <= '0;
            adder_b   <= '0;
            sum_q     <= '0;
            cycles_q  <= '0;
            err_q     <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q    <= '0;
                    settle_q <= '0;
`ifdef ADDER_MEAS_LFSR_EN
                    if (self_issue) begin
                        adder_a <= WIDTH'(lfsr_a);
                        adder_b <= WIDTH'(lfsr_b);
                    end else if (start) begin
                        adder_a <= bus.cmd_a;
                        adder_b <= bus.cmd_b;
                    end
`else
                    if (start) begin
                        adder_a <= bus.cmd_a;
                        adder_b <= bus.cmd_b;
                    end
`endif
                end
                LOAD: begin
                    if (settle_q < CNT_W'(SETTLE - 1)) begin
                        settle_q <= settle_q + CNT_W'(1);
                    end
                    // So the counter reads 1 during the first RUN cycle.
                    cnt_q <= CNT_W'(1);
                end
                RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (chain_rise) begin
                        cycles_q <= cnt_q;
                    end else if (timed_out) begin
                        sum_q     <= '0;
                        cycles_q  <= cnt_q;
                        err_q     <= 1'b1;
                        timeout_q <= 1'b1;
                    end
                end
                CAPTURE: begin
                    sum_q     <= adder_sum;
                    err_q     <= sum_mismatch(adder_a, adder_b, adder_sum);
                    timeout_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.res_sum     = sum_q;
    assign bus.res_cycles  = cycles_q;
    assign bus.res_err     = err_q;
    assign bus.res_timeout = timeout_q;

endmodule

// File: tb/tb_adder_meas_sequencer.sv
// ---------------------------------------------------------------------------
// tb_adder_meas_sequencer
// Drives the sequencer with directed and randomised commands while modelling
// the adder (chain flag and sum) from the bench side, and compares every
// result record against a record computed from the timing/checking rules.
// ---------------------------------------------------------------------------
module tb_adder_meas_sequencer;
    import adder_meas_pkg::*;

    localparam int TIMEOUT = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        active;
    logic        sweep_en;
    logic [31:0] adder_a;
    logic [31:0] adder_b;
    logic        adder_run;
    logic        adder_chain;
    logic [31:0] adder_sum;

    int checks   = 0;
    int failures = 0;

    adder_meas_sequencer_if #(.WIDTH(32), .CNT_W(16)) bus ();

    adder_meas_sequencer #(
        .WIDTH   (32),
        .CNT_W   (16),
        .TIMEOUT (TIMEOUT),
        .SETTLE  (2)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_n    (rst_n),
        .active      (active),
`ifdef ADDER_MEAS_LFSR_EN
        .sweep_en    (sweep_en),
`endif
        .bus         (bus),
        .adder_a     (adder_a),
        .adder_b     (adder_b),
        .adder_run   (adder_run),
        .adder_chain (adder_chain),
        .adder_sum   (adder_sum)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Expected record: the chain, raised during RUN cycle `delay`, is seen
    // two cycles later; if that lands beyond TIMEOUT RUN cycles (or never
    // happens, delay<1) the run aborts.
    function automatic meas_res_t model(input logic [31:0] a, input logic [31:0] b,
                                        input int delay, input logic [31:0] sumv);
        meas_res_t   r;
        logic [31:0] want;
        want = a + b;
        if (delay < 1 || delay + 2 > TIMEOUT) begin
            r.sum     = '0;
            r.cycles  = 16'(TIMEOUT);
            r.err     = 1'b1;
            r.timeout = 1'b1;
        end else begin
            r.sum     = sumv;
            r.cycles  = 16'(delay + 2);
            r.err     = (sumv != want);
            r.timeout = 1'b0;
        end
        return r;
    endfunction

    task automatic wait_ready();
        int i;
        i = 0;
        while (!bus.cmd_ready && i < 100) begin
            @(negedge clk);
            i++;
        end
        check_eq("cmd_ready_wait", bus.cmd_ready, 1);
    endtask

    task automatic do_cmd(input logic [31:0] a, input logic [31:0] b, input int delay,
                          input logic [31:0] sumv, input int hold, input bit stale);
        meas_res_t exp;
        int        k;
        int        n;
        bit        seen;
        exp = model(a, b, delay, sumv);
        adder_sum = ~sumv;
        if (stale) begin
            adder_chain = 1'b1;
            repeat (3) @(negedge clk);
        end
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = $urandom;
        bus.cmd_b     = $urandom;
        check_eq("adder_a", adder_a, a);
        check_eq("adder_b", adder_b, b);
        check_eq("busy_ready", bus.cmd_ready, 0);
        if (stale) begin
            n = 0;
            repeat (5) begin
                if (adder_run) n++;
                @(negedge clk);
            end
            check_eq("stale_hold", n, 0);
            adder_chain = 1'b0;
        end
        k    = 0;
        seen = 1'b0;
        for (int i = 0; i < TIMEOUT + 60 && !seen; i++) begin
            if (bus.res_valid) begin
                seen = 1'b1;
            end else begin
                if (adder_run) begin
                    k++;
                    if (k == delay) begin
                        adder_chain = 1'b1;
                        adder_sum   = sumv;
                    end
                end
                @(negedge clk);
            end
        end
        adder_chain = 1'b0;
        check_eq("res_seen", seen, 1);
        check_eq("res_sum", bus.res_sum, exp.sum);
        check_eq("res_cycles", bus.res_cycles, exp.cycles);
        check_eq("res_err", bus.res_err, exp.err);
        check_eq("res_timeout", bus.res_timeout, exp.timeout);
        // Hold the record and try a second command that must be refused.
        bus.res_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_a     = ~a;
            @(negedge clk);
            check_eq("hold_valid", bus.res_valid, 1);
            check_eq("hold_ready", bus.cmd_ready, 0);
            check_eq("hold_record", {bus.res_sum, bus.res_cycles, bus.res_err, bus.res_timeout},
                     {exp.sum, exp.cycles, exp.err, exp.timeout});
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_eq("res_dropped", bus.res_valid, 0);
        check_eq("no_second_cmd", adder_a, a);
    endtask

    task automatic start_and_run();
        int i;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_a     = $urandom;
        bus.cmd_b     = $urandom;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        i = 0;
        while (!adder_run && i < 20) begin
            @(negedge clk);
            i++;
        end
        check_eq("run_reached", adder_run, 1);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        int          d;
        rst_n         = 1'b0;
        active        = 1'b1;
        sweep_en      = 1'b0;
        adder_chain   = 1'b0;
        adder_sum     = '0;
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_res_valid", bus.res_valid, 0);
        check_eq("rst_adder_run", adder_run, 0);
        check_eq("rst_adder_a", adder_a, 0);
        check_eq("rst_adder_b", adder_b, 0);
        check_eq("rst_res_cycles", bus.res_cycles, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_cmd(32'd5, 32'd7, 10, 32'd12, 5, 1'b0);
        do_cmd(32'hFFFF_FFFF, 32'd1, 4, 32'd0, 1, 1'b0);
        do_cmd(32'hFFFF_FFFF, 32'd1, 4, 32'd1, 0, 1'b0);
        do_cmd(32'h1234_5678, 32'h0101_0101, -1, 32'h0, 2, 1'b0);
        do_cmd(32'h0000_0003, 32'h0000_0004, TIMEOUT - 2, 32'd7, 0, 1'b0);
        do_cmd(32'h0000_0003, 32'h0000_0004, TIMEOUT - 1, 32'd7, 0, 1'b0);
        do_cmd(32'hA5A5_0000, 32'h0000_5A5A, 3, 32'hA5A5_5A5A, 1, 1'b1);

        for (int t = 0; t < 20; t++) begin
            a = $urandom;
            b = $urandom;
            d = int'($urandom_range(1, 30));
            s = ($urandom_range(0, 1) == 0) ? a + b : $urandom;
            do_cmd(a, b, d, s, int'($urandom_range(0, 3)), 1'b0);
        end

        start_and_run();
        active = 1'b0;
        @(negedge clk);
        check_eq("inactive_run", adder_run, 0);
        check_eq("inactive_valid", bus.res_valid, 0);
        active = 1'b1;
        #1;
        check_eq("reactive_idle", bus.cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("no_res_after_abort", bus.res_valid, 0);
        end

        start_and_run();
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("midrun_rst_run", adder_run, 0);
        check_eq("midrun_rst_a", adder_a, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("midrun_rst_idle", bus.cmd_ready, 1);

`ifdef ADDER_MEAS_LFSR_EN
        sweep_en = 1'b1;
        @(negedge clk);
        sweep_en = 1'b0;
        check_eq("lfsr_a", adder_a, 32'h8020_0003);
        check_eq("lfsr_b", adder_b, 32'hC030_0002);
        active = 1'b0;
        @(negedge clk);
        active = 1'b1;
        @(negedge clk);
`endif

        do_cmd(32'd100, 32'd23, 6, 32'd123, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
